fan_angle_tick: RTL
===================

# fan_angle_tick

Hall-sensor front end for the LED fan display. It measures the fan's rotation period from the once-per-revolution hall pulse and divides it by the number of angular steps. It then emits one single-cycle degree tick (`fanclk`) per step, aligned to the index mark. Its outputs drive the `fanclk` input of the degree-counter/LED pattern stage directly downstream.

## Interface
- `DEG_PER_REV`, 360: ticks per revolution; must match the downstream degree counter range.
- `PERIOD_W`, 24: width of the period counter, captured period and step.
- `MIN_PERIOD`, 3600: smallest accepted revolution period, in clk cycles.
- `DEBOUNCE`, 4: consecutive equal synchronized samples required to accept a hall level change.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `hall`  in  1  raw hall sensor, asynchronous to clk; active high while the magnet passes.
- `fanclk`  out  1  single-cycle degree tick.
- `index`  out  1  single-cycle pulse on each accepted hall rising edge.
- `locked`  out  1  a valid step is loaded and ticks are being generated.
- `step`  out  PERIOD_W  current tick spacing in clk cycles.

## Operation
- **Input conditioning**
  - `hall` passes through a 2-FF synchronizer.
  - The filtered level changes only after `DEBOUNCE` consecutive equal synchronized samples differing from the current filtered level.
  - A filtered 0→1 transition is an index event; `index` is high for that one cycle.
- **Period counter `pcnt`**
  - In an index cycle: capture P = `pcnt`+1, then `pcnt` ← 0.
  - Otherwise: `pcnt` increments, saturating at 2^PERIOD_W−1.
  - Saturation is a stall:
    - `locked` ← 0, divider aborted, tick generation stops.
    - The next index only re-arms; its P is discarded.
- **Period validity**
  - P is valid only if it is not the first index after reset or stall, P ≥ `MIN_PERIOD`, and `pcnt` never saturated.
  - Invalid P: `locked` ← 0; divider not started.
- **Divider**
  - Sequential restoring divider computes Q = floor(P / `DEG_PER_REV`), one quotient bit per cycle.
  - Starts in the cycle after a valid index; result is ready `PERIOD_W` cycles after start.
  - On completion: `step` ← Q, `locked` ← 1.
  - An index event while busy aborts it. The divider restarts on the new P if that P is valid.
- **Tick generator**
  - Armed at the first index event occurring while `locked`=1.
  - In each index cycle while armed:
    - `fanclk`=1 (tick 0).
    - Phase counter ← 0.
    - Tick count ← 1.
  - After the index cycle: a further tick whenever the phase counter reaches `step`−1, then the phase counter ← 0.
  - At most `DEG_PER_REV` ticks per index interval. Once the tick count reaches `DEG_PER_REV`, ticks stop until the next index.
  - If an index arrives early, the remaining ticks are dropped; `index` lets downstream resync.
  - A new `step` takes effect at the next tick interval boundary.
  - `locked` falling disarms the generator and clears the phase and tick count.

## Timing
- **Reset (`rst`=0, asynchronous):**
  - `fanclk`=0, `index`=0, `locked`=0, `step`=0.
  - `pcnt`, synchronizer, filter, divider and tick state all cleared.
  - The filtered level resets to 0.
- **Latency:** raw hall rise → `index` high = 2 + `DEBOUNCE` cycles (6 at defaults), for a clean edge.
- **Divider:** valid index → `locked`/`step` update = 1 + `PERIOD_W` cycles (25 at defaults).
- **Tick timing:** tick k (k ≥ 1) occurs k·`step` cycles after tick 0, for k < `DEG_PER_REV`.
- **Simultaneous events:**
  - Index and phase expiry in the same cycle: exactly one `fanclk` pulse, counted as tick 0.
  - Index and divider completion in the same cycle: abort wins; the old result is discarded.
- **Mid-operation reset:** asynchronous reset clears all state immediately; no partial tick is emitted.

## Test plan
- **Reset:** hold `rst`=0 for 10 cycles with `hall` toggling → all outputs 0. Release → `locked`=0 until two valid indexes have passed.
- **Steady rotation:** hall period 36000 cycles, 200-cycle high pulse.
  - No lock after the first index.
  - Second index → `locked`=1 and `step`=100 after 25 cycles.
  - From the third index on, exactly 360 `fanclk` pulses per revolution, 100 cycles apart, the first coincident with `index`.
- **Debounce:** 3-cycle hall glitch → no `index`, `pcnt` unaffected. 4-cycle pulse → `index` 6 cycles after the rise.
- **Short period:** hall period 1000 → `locked` stays 0, no `fanclk`.
- **Non-integer period and cap:** hall period 36100 → `step`=100. All 360 ticks are issued by cycle 35900 after the index, then no further tick until the next index (100-cycle gap).
- **Stall and restart:**
  - Stop hall → `locked` falls when `pcnt` reaches 2^24−1, and `fanclk` stops.
  - Resume at 72000 cycles: first index discarded; second index → `step`=200, ticks resume at the following index.

Source files
------------

// File: rtl/fan_angle_tick.sv
// Hall-sensor front end: debounces the once-per-revolution hall pulse,
// measures the revolution period, divides it into DEG_PER_REV steps and
// emits one fanclk tick per step, with tick 0 aligned to the index mark.
module fan_angle_tick #(
    parameter int DEG_PER_REV = 360,
    parameter int PERIOD_W    = 24,
    parameter int MIN_PERIOD  = 3600,
    parameter int DEBOUNCE    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hall,
    output logic                fanclk,
    output logic                index,
    output logic                locked,
    output logic [PERIOD_W-1:0] step
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int TC_W = $clog2(DEG_PER_REV + 1);
    localparam int DC_W = $clog2(PERIOD_W + 1);

    localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;
    localparam logic [PERIOD_W:0]   MIN_P    = (PERIOD_W+1)'(MIN_PERIOD);
    localparam logic [PERIOD_W:0]   DIVISOR  = (PERIOD_W+1)'(DEG_PER_REV);
    localparam logic [TC_W-1:0]     TICKS    = TC_W'(DEG_PER_REV);

    // input conditioning
    logic            hall_s1, hall_s2;
    logic            filt;
    logic [DB_W-1:0] db_cnt;
    logic            db_accept;

    // period measurement
    logic [PERIOD_W-1:0] pcnt;
    logic [PERIOD_W:0]   period_p;
    logic                pcnt_sat;
    logic                have_ref;
    logic                p_valid;
    logic                stall;

    // divider
    logic                div_busy;
    logic [DC_W-1:0]     div_cnt;
    logic [PERIOD_W-1:0] div_rem, div_quo;
    logic [PERIOD_W:0]   div_trial, div_diff;
    logic                div_ge;
    logic [PERIOD_W-1:0] div_rem_nx, div_quo_nx;
    logic                div_last;

    // tick generator
    logic                armed;
    logic [PERIOD_W-1:0] phase, cur_step, step_m1;
    logic [TC_W-1:0]     tcnt;
    logic                phase_tick;

    // Two-flop synchronizer for the asynchronous hall input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hall_s1 <= 1'b0;
            hall_s2 <= 1'b0;
        end else begin
            // NOTE: non-blocking so hall_s2 takes the old hall_s1, giving two real stages.
            hall_s1 <= hall;
            hall_s2 <= hall_s1;
        end
    end

    assign db_accept = (hall_s2 != filt) && (db_cnt == DB_W'(DEBOUNCE - 1));

    // Debounce filter; a qualified rising level produces the one-cycle index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt   <= 1'b0;
            db_cnt <= '0;
            index  <= 1'b0;
        end else begin
            index <= db_accept && hall_s2;
            if (hall_s2 == filt) begin
                db_cnt <= '0;
            end else if (db_accept) begin
                filt   <= hall_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign pcnt_sat = (pcnt == PCNT_MAX);
    assign period_p = {1'b0, pcnt} + (PERIOD_W+1)'(1);
    assign p_valid  = have_ref && !pcnt_sat && (period_p >= MIN_P);
    assign stall    = !index && pcnt_sat;

    // Period counter; saturation drops the reference so the next index only re-arms.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt     <= '0;
            have_ref <= 1'b0;
        end else if (index) begin
            pcnt     <= '0;
            have_ref <= 1'b1;
        end else if (!pcnt_sat) begin
            pcnt <= pcnt + PERIOD_W'(1);
        end else begin
            have_ref <= 1'b0;
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        // NOTE: every output of this block is assigned on every pass, so no latch is inferred.
        div_trial  = {div_rem, div_quo[PERIOD_W-1]};
        div_diff   = div_trial - DIVISOR;
        div_ge     = (div_trial >= DIVISOR);
        div_rem_nx = div_ge ? div_diff[PERIOD_W-1:0] : div_trial[PERIOD_W-1:0];
        div_quo_nx = {div_quo[PERIOD_W-2:0], div_ge};
    end

    assign div_last = (div_cnt == DC_W'(PERIOD_W - 1));

    // Divider sequencing plus lock/step state; an index always beats a completing divide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_busy <= 1'b0;
            div_cnt  <= '0;
            div_rem  <= '0;
            div_quo  <= '0;
            locked   <= 1'b0;
            step     <= '0;
        end else if (index) begin
            if (p_valid) begin
                div_busy <= 1'b1;
                div_cnt  <= '0;
                div_rem  <= '0;
                div_quo  <= period_p[PERIOD_W-1:0];
            end else begin
                div_busy <= 1'b0;
                locked   <= 1'b0;
            end
        end else if (stall) begin
            div_busy <= 1'b0;
            locked   <= 1'b0;
        end else if (div_busy) begin
            div_rem <= div_rem_nx;
            div_quo <= div_quo_nx;
            div_cnt <= div_cnt + DC_W'(1);
            if (div_last) begin
                div_busy <= 1'b0;
                step     <= div_quo_nx;
                locked   <= 1'b1;
            end
        end
    end

    assign step_m1    = cur_step - PERIOD_W'(1);
    assign phase_tick = armed && locked && !index && (tcnt < TICKS) && (phase == step_m1);
    assign fanclk     = (index && locked) || phase_tick;

    // Tick generator: tick 0 on index, then one tick per step, capped per revolution.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed    <= 1'b0;
            phase    <= '0;
            tcnt     <= '0;
            cur_step <= '0;
        end else if (!locked) begin
            armed    <= 1'b0;
            phase    <= '0;
            tcnt     <= '0;
            cur_step <= '0;
        end else if (index) begin
            armed    <= 1'b1;
            phase    <= '0;
            tcnt     <= TC_W'(1);
            cur_step <= step;
        end else if (armed) begin
            if (phase_tick) begin
                phase    <= '0;
                tcnt     <= tcnt + TC_W'(1);
                cur_step <= step;
            end else if (tcnt < TICKS) begin
                phase <= phase + PERIOD_W'(1);
            end
        end
    end

endmodule
